game_turn_ctrl: RTL and testbench

GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

---
 rtl/game_turn_ctrl.sv | 162 ++++++++++++++++
 tb/tb_game_turn_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_turn_ctrl.sv
// Turn controller for a two-row "add hands" game.
// Each player moves a source hand onto an opponent hand; the destination becomes (src + dst) mod 10.
module game_turn_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_ok,
    input  logic [2:0]  num,
    output logic [39:0] status,
    output logic [3:0]  cursor,
    output logic        player,
    output logic [3:0]  src_idx,
    output logic        src_valid,
    output logic [2:0]  state,
    output logic        game_over,
    output logic        winner
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEL_SRC = 3'd1,
        SEL_DST = 3'd2,
        UPDATE  = 3'd3,
        CHECK   = 3'd4,
        OVER    = 3'd5
    } state_t;

    state_t     cur_state;
    logic [2:0] hands;
    logic [3:0] dst_idx;

    logic [2:0] hands_new;
    logic       cur_row;
    logic [2:0] cur_col;
    logic [2:0] last_col;
    logic [3:0] cur_val;
    logic [3:0] src_val;
    logic [3:0] dst_val;
    logic [4:0] sum;
    logic [3:0] sum_val;
    logic       own_row;
    logic       opp_clear;
    logic [3:0] next_toggle;
    logic [3:0] next_left;
    logic [3:0] next_right;

    function automatic logic [3:0] slot_of(input logic row, input logic [2:0] col);
        return row ? ({1'b0, col} + 4'd5) : {1'b0, col};
    endfunction

    function automatic logic [39:0] init_slots(input logic [2:0] cnt);
        logic [39:0] s;
        s = '0;
        for (int k = 0; k < 5; k++) begin
            if (k < int'(cnt)) begin
                s[4*k +: 4]     = 4'd1;
                s[4*(k+5) +: 4] = 4'd1;
            end
        end
        return s;
    endfunction

    assign state = cur_state;

    // Cursor geometry, slot lookups and the pending mod-10 sum.
    always_comb begin
        hands_new = num;
        if (num == 3'd0) begin
            hands_new = 3'd1;
        end else if (num > 3'd5) begin
            hands_new = 3'd5;
        end
        cur_row     = (cursor >= 4'd5);
        cur_col     = cur_row ? 3'(cursor - 4'd5) : cursor[2:0];
        last_col    = hands - 3'd1;
        cur_val     = status[{cursor, 2'b00} +: 4];
        src_val     = status[{src_idx, 2'b00} +: 4];
        dst_val     = status[{dst_idx, 2'b00} +: 4];
        sum         = {1'b0, src_val} + {1'b0, dst_val};
        sum_val     = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
        own_row     = (cur_row == player);
        opp_clear   = player ? (status[19:0] == 20'd0) : (status[39:20] == 20'd0);
        next_toggle = slot_of(~cur_row, cur_col);
        next_left   = (cur_col == 3'd0) ? slot_of(~cur_row, last_col) : cursor - 4'd1;
        next_right  = (cur_col == last_col) ? slot_of(~cur_row, 3'd0) : cursor + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
            status    <= '0;
            cursor    <= '0;
            player    <= 1'b0;
            src_idx   <= '0;
            src_valid <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            hands     <= 3'd1;
            dst_idx   <= '0;
        end else begin
            case (cur_state)
                IDLE, OVER: begin
                    if (start) begin
                        hands     <= hands_new;
                        status    <= init_slots(hands_new);
                        player    <= 1'b0;
                        cursor    <= '0;
                        src_valid <= 1'b0;
                        game_over <= 1'b0;
                        cur_state <= SEL_SRC;
                    end
                end
                SEL_SRC, SEL_DST: begin
                    // btn_ok consumes the cycle even when it is rejected.
                    if (btn_ok) begin
                        if (cur_state == SEL_SRC) begin
                            if (own_row && cur_val != 4'd0) begin
                                src_idx   <= cursor;
                                src_valid <= 1'b1;
                                cur_state <= SEL_DST;
                            end
                        end else if (cursor == src_idx) begin
                            src_valid <= 1'b0;
                            cur_state <= SEL_SRC;
                        end else if (!own_row && cur_val != 4'd0) begin
                            dst_idx   <= cursor;
                            cur_state <= UPDATE;
                        end
                    end else if (btn_up || btn_down) begin
                        cursor <= next_toggle;
                    end else if (btn_left) begin
                        cursor <= next_left;
                    end else if (btn_right) begin
                        cursor <= next_right;
                    end
                end
                UPDATE: begin
                    status[{dst_idx, 2'b00} +: 4] <= sum_val;
                    src_valid <= 1'b0;
                    cur_state <= CHECK;
                end
                CHECK: begin
                    if (opp_clear) begin
                        game_over <= 1'b1;
                        winner    <= player;
                        cur_state <= OVER;
                    end else begin
                        player    <= ~player;
                        cursor    <= player ? 4'd0 : 4'd5;
                        cur_state <= SEL_SRC;
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench for game_turn_ctrl: reset, setup, cursor moves, selection rules,
// full turns with mod-10 wrap, reset during UPDATE and a complete game to OVER.
module tb_game_turn_ctrl;

    localparam int B_OK    = 0;
    localparam int B_UP    = 1;
    localparam int B_DOWN  = 2;
    localparam int B_LEFT  = 3;
    localparam int B_RIGHT = 4;
    localparam int B_START = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_ok;
    logic [2:0]  num;
    logic [39:0] status;
    logic [3:0]  cursor;
    logic        player;
    logic [3:0]  src_idx;
    logic        src_valid;
    logic [2:0]  state;
    logic        game_over;
    logic        winner;

    int errors = 0;
    int checks = 0;
    int cur;
    logic pl;

    game_turn_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_ok(btn_ok), .num(num),
        .status(status), .cursor(cursor), .player(player),
        .src_idx(src_idx), .src_valid(src_valid), .state(state),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic int row_of(input int s);
        return (s >= 5) ? 1 : 0;
    endfunction

    function automatic int col_of(input int s);
        return (s >= 5) ? s - 5 : s;
    endfunction

    task automatic clear_inputs();
        start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_ok = 0;
    endtask

    task automatic press(input int b);
        @(negedge clk);
        case (b)
            B_OK:    btn_ok = 1;
            B_UP:    btn_up = 1;
            B_DOWN:  btn_down = 1;
            B_LEFT:  btn_left = 1;
            B_RIGHT: btn_right = 1;
            default: start = 1;
        endcase
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic new_game(input logic [2:0] nn);
        num = nn;
        press(B_START);
        cur = 0;
        pl = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic goto(input int target);
        if (row_of(target) != row_of(cur)) begin
            press(B_UP);
            cur = (cur >= 5) ? cur - 5 : cur + 5;
        end
        while (col_of(cur) < col_of(target)) begin
            press(B_RIGHT);
            cur++;
        end
        while (col_of(cur) > col_of(target)) begin
            press(B_LEFT);
            cur--;
        end
    endtask

    task automatic play_turn(input int s, input int d);
        goto(s);
        press(B_OK);
        goto(d);
        press(B_OK);
        repeat (2) @(negedge clk);
        pl = ~pl;
        cur = pl ? 5 : 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        num = 3'd0;
        repeat (2) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        checks++; if (status !== 40'd0) begin errors++; $display("[TB] FAIL reset_status: got %h expected 0", status); end
        checks++; if (cursor !== 4'd0) begin errors++; $display("[TB] FAIL reset_cursor: got %0d expected 0", cursor); end
        checks++; if (player !== 1'b0) begin errors++; $display("[TB] FAIL reset_player: got %0d expected 0", player); end
        checks++; if (src_idx !== 4'd0) begin errors++; $display("[TB] FAIL reset_src_idx: got %0d expected 0", src_idx); end
        checks++; if (src_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_src_valid: got %0d expected 0", src_valid); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL reset_game_over: got %0d expected 0", game_over); end
        checks++; if (winner !== 1'b0) begin errors++; $display("[TB] FAIL reset_winner: got %0d expected 0", winner); end
        rst = 0;
        repeat (2) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL idle_hold: got %0d expected 0", state); end
    endtask

    task automatic test_clamp();
        new_game(3'd0);
        checks++; if (status !== 40'h00001_00001) begin errors++; $display("[TB] FAIL clamp_num0: got %h expected 0000100001", status); end
        pulse_reset();
        new_game(3'd7);
        checks++; if (status !== 40'h11111_11111) begin errors++; $display("[TB] FAIL clamp_num7: got %h expected 1111111111", status); end
        pulse_reset();
    endtask

    task automatic test_start();
        new_game(3'd3);
        checks++; if (status !== 40'h00111_00111) begin errors++; $display("[TB] FAIL start_status: got %h expected 0011100111", status); end
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL start_state: got %0d expected 1", state); end
        checks++; if (player !== 1'b0) begin errors++; $display("[TB] FAIL start_player: got %0d expected 0", player); end
        checks++; if (cursor !== 4'd0) begin errors++; $display("[TB] FAIL start_cursor: got %0d expected 0", cursor); end
        num = 3'd5;
        press(B_START);
        checks++; if (status !== 40'h00111_00111) begin errors++; $display("[TB] FAIL start_ignored: got %h expected 0011100111", status); end
        pulse_reset();
    endtask

    task automatic test_cursor();
        new_game(3'd2);
        press(B_LEFT);
        checks++; if (cursor !== 4'd6) begin errors++; $display("[TB] FAIL cursor_left_wrap: got %0d expected 6", cursor); end
        press(B_RIGHT);
        checks++; if (cursor !== 4'd0) begin errors++; $display("[TB] FAIL cursor_right_wrap: got %0d expected 0", cursor); end
        press(B_UP);
        checks++; if (cursor !== 4'd5) begin errors++; $display("[TB] FAIL cursor_up: got %0d expected 5", cursor); end
        press(B_RIGHT);
        checks++; if (cursor !== 4'd6) begin errors++; $display("[TB] FAIL cursor_right: got %0d expected 6", cursor); end
        press(B_DOWN);
        checks++; if (cursor !== 4'd1) begin errors++; $display("[TB] FAIL cursor_down: got %0d expected 1", cursor); end
        press(B_LEFT);
        checks++; if (cursor !== 4'd0) begin errors++; $display("[TB] FAIL cursor_left: got %0d expected 0", cursor); end
        cur = 0;
    endtask

    task automatic test_priority();
        @(negedge clk);
        btn_ok = 1;
        btn_left = 1;
        @(negedge clk);
        clear_inputs();
        checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL prio_state: got %0d expected 2", state); end
        checks++; if (cursor !== 4'd0) begin errors++; $display("[TB] FAIL prio_cursor: got %0d expected 0", cursor); end
        checks++; if (src_idx !== 4'd0) begin errors++; $display("[TB] FAIL prio_src_idx: got %0d expected 0", src_idx); end
        checks++; if (src_valid !== 1'b1) begin errors++; $display("[TB] FAIL prio_src_valid: got %0d expected 1", src_valid); end
    endtask

    task automatic test_select_rules();
        press(B_OK);
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL deselect_state: got %0d expected 1", state); end
        checks++; if (src_valid !== 1'b0) begin errors++; $display("[TB] FAIL deselect_valid: got %0d expected 0", src_valid); end
        press(B_UP);
        press(B_OK);
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL src_opp_row: got %0d expected 1", state); end
        checks++; if (src_valid !== 1'b0) begin errors++; $display("[TB] FAIL src_opp_valid: got %0d expected 0", src_valid); end
        press(B_DOWN);
        press(B_OK);
        press(B_RIGHT);
        press(B_OK);
        checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL dst_own_row: got %0d expected 2", state); end
        checks++; if (src_idx !== 4'd0) begin errors++; $display("[TB] FAIL dst_own_src: got %0d expected 0", src_idx); end
        press(B_LEFT);
        press(B_OK);
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL dst_deselect: got %0d expected 1", state); end
        pulse_reset();
    endtask

    task automatic test_turn();
        new_game(3'd2);
        play_turn(0, 5);
        play_turn(6, 1);
        play_turn(0, 5);
        play_turn(6, 0);
        play_turn(0, 5);
        play_turn(5, 0);
        checks++; if (status !== 40'h00015_00027) begin errors++; $display("[TB] FAIL turn_setup: got %h expected 0001500027", status); end
        checks++; if (player !== 1'b0) begin errors++; $display("[TB] FAIL turn_setup_player: got %0d expected 0", player); end
        goto(0);
        press(B_OK);
        goto(5);
        press(B_OK);
        checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL turn_update: got %0d expected 3", state); end
        @(negedge clk);
        checks++; if (state !== 3'd4) begin errors++; $display("[TB] FAIL turn_check: got %0d expected 4", state); end
        checks++; if (status !== 40'h00012_00027) begin errors++; $display("[TB] FAIL turn_sum: got %h expected 0001200027", status); end
        @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL turn_next_state: got %0d expected 1", state); end
        checks++; if (player !== 1'b1) begin errors++; $display("[TB] FAIL turn_player: got %0d expected 1", player); end
        checks++; if (cursor !== 4'd5) begin errors++; $display("[TB] FAIL turn_cursor: got %0d expected 5", cursor); end
        checks++; if (src_valid !== 1'b0) begin errors++; $display("[TB] FAIL turn_src_valid: got %0d expected 0", src_valid); end
        pl = 1'b1;
        cur = 5;
    endtask

    task automatic test_zero_src();
        play_turn(6, 0);
        play_turn(0, 5);
        checks++; if (status !== 40'h00010_00028) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected 0001000028", status); end
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL wrap_not_over: got %0d expected 1", state); end
        press(B_OK);
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL zero_src_state: got %0d expected 1", state); end
        checks++; if (src_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_src_valid: got %0d expected 0", src_valid); end
    endtask

    task automatic test_reset_update();
        goto(6);
        press(B_OK);
        goto(0);
        press(B_OK);
        checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL abort_in_update: got %0d expected 3", state); end
        #1 rst = 1;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL abort_state: got %0d expected 0", state); end
        checks++; if (status !== 40'd0) begin errors++; $display("[TB] FAIL abort_status: got %h expected 0", status); end
        checks++; if (cursor !== 4'd0) begin errors++; $display("[TB] FAIL abort_cursor: got %0d expected 0", cursor); end
        checks++; if (player !== 1'b0) begin errors++; $display("[TB] FAIL abort_player: got %0d expected 0", player); end
        checks++; if (src_idx !== 4'd0) begin errors++; $display("[TB] FAIL abort_src_idx: got %0d expected 0", src_idx); end
        checks++; if (src_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_src_valid: got %0d expected 0", src_valid); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL abort_game_over: got %0d expected 0", game_over); end
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        checks++; if (status !== 40'd0) begin errors++; $display("[TB] FAIL abort_no_write: got %h expected 0", status); end
    endtask

    task automatic test_game_over();
        new_game(3'd1);
        for (int t = 0; t < 12; t++) begin
            if (pl) play_turn(5, 0);
            else play_turn(0, 5);
        end
        checks++; if (status !== 40'h00003_00007) begin errors++; $display("[TB] FAIL over_setup: got %h expected 0000300007", status); end
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL over_setup_state: got %0d expected 1", state); end
        play_turn(0, 5);
        checks++; if (state !== 3'd5) begin errors++; $display("[TB] FAIL over_state: got %0d expected 5", state); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("[TB] FAIL over_flag: got %0d expected 1", game_over); end
        checks++; if (winner !== 1'b0) begin errors++; $display("[TB] FAIL over_winner: got %0d expected 0", winner); end
        checks++; if (status !== 40'h00000_00007) begin errors++; $display("[TB] FAIL over_status: got %h expected 0000000007", status); end
        press(B_UP);
        press(B_OK);
        press(B_LEFT);
        checks++; if (cursor !== 4'd5) begin errors++; $display("[TB] FAIL over_cursor_hold: got %0d expected 5", cursor); end
        checks++; if (status !== 40'h00000_00007) begin errors++; $display("[TB] FAIL over_status_hold: got %h expected 0000000007", status); end
        checks++; if (state !== 3'd5) begin errors++; $display("[TB] FAIL over_state_hold: got %0d expected 5", state); end
        new_game(3'd3);
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL restart_state: got %0d expected 1", state); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL restart_flag: got %0d expected 0", game_over); end
        checks++; if (status !== 40'h00111_00111) begin errors++; $display("[TB] FAIL restart_status: got %h expected 0011100111", status); end
        checks++; if (cursor !== 4'd0) begin errors++; $display("[TB] FAIL restart_cursor: got %0d expected 0", cursor); end
    endtask

    initial begin
        cur = 0;
        pl = 1'b0;
        test_reset();
        test_clamp();
        test_start();
        test_cursor();
        test_priority();
        test_select_rules();
        test_turn();
        test_zero_src();
        test_reset_update();
        test_game_over();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
